// File: rtl/hdr_frame_reader.sv
// Frame reader: fetches packed RGB565 words from RAM with one request in flight,
// buffers them in a small FIFO and hands out one pixel per pixel_req.
module hdr_frame_reader #(
    parameter int WORDS_PER_FRAME = 38400,
    parameter int BASE_ADDR       = 0,
    parameter int ADDR_W          = 24,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              ram_busy,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [127:0]      rd_data,
    input  logic              rd_valid,
    input  logic              pixel_req,
    output logic              pixel_valid,
    output logic [4:0]        red,
    output logic [5:0]        green,
    output logic [4:0]        blue,
    output logic              underflow,
    output logic              frame_read_done
);

    localparam int WI_W  = $clog2(WORDS_PER_FRAME + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PC_W  = $clog2(WORDS_PER_FRAME * 8);

    localparam logic [WI_W-1:0]   WPF_C      = WI_W'(WORDS_PER_FRAME);
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [PC_W-1:0]   LAST_PIX_C = PC_W'(WORDS_PER_FRAME * 8 - 1);
    localparam logic [ADDR_W-1:0] BASE_C     = ADDR_W'(BASE_ADDR);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WI_W-1:0]  words_issued;
    logic [127:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       sub_idx;
    logic [PC_W-1:0]  pix_cnt;
    logic             drop;
    logic             fifo_empty;
    logic             push;
    logic             pix_fire;
    logic             pop;
    logic [127:0]     head_word;
    logic [15:0]      head_pix;

    assign fifo_empty = (fifo_cnt == '0);
    assign head_word  = fifo_mem[rd_ptr];
    assign head_pix   = head_word[{sub_idx, 4'b0000} +: 16];

    // A request waits for a free slot and for any aborted read to come back first.
    assign rd_req  = (state == S_FETCH) && !frame_start && !ram_busy
                     && (fifo_cnt < DEPTH_C) && !drop;
    assign rd_addr = rd_req ? (BASE_C + ADDR_W'(words_issued)) : '0;

    assign push     = (state == S_WAIT) && rd_valid && !frame_start;
    assign pix_fire = pixel_req && !frame_start && !fifo_empty;
    assign pop      = pix_fire && (sub_idx == 3'd7);

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_nxt = fifo_cnt;
        case ({push, pop})
            2'b10:   cnt_nxt = fifo_cnt + 1'b1;
            2'b01:   cnt_nxt = fifo_cnt - 1'b1;
            default: cnt_nxt = fifo_cnt;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            state_nxt = S_FETCH;
        end else begin
            case (state)
                S_FETCH: if (rd_req) state_nxt = S_WAIT;
                S_WAIT:  if (rd_valid) state_nxt = (words_issued < WPF_C) ? S_FETCH : S_DRAIN;
                // Leaving DRAIN on the final pop lines IDLE up with frame_read_done.
                S_DRAIN: if (cnt_nxt == '0) state_nxt = S_IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // NOTE: the FIFO storage has no reset; occupancy and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rd_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            words_issued    <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_cnt        <= '0;
            sub_idx         <= '0;
            pix_cnt         <= '0;
            drop            <= 1'b0;
            pixel_valid     <= 1'b0;
            red             <= '0;
            green           <= '0;
            blue            <= '0;
            underflow       <= 1'b0;
            frame_read_done <= 1'b0;
        end else begin
            state <= state_nxt;
            if (frame_start) begin
                words_issued    <= '0;
                wr_ptr          <= '0;
                rd_ptr          <= '0;
                fifo_cnt        <= '0;
                sub_idx         <= '0;
                pix_cnt         <= '0;
                // An in-flight read must still return before the new frame may issue.
                drop            <= (drop || (state == S_WAIT)) && !rd_valid;
                underflow       <= 1'b0;
                pixel_valid     <= 1'b0;
                frame_read_done <= 1'b0;
            end else begin
                if (rd_req) words_issued <= words_issued + 1'b1;
                if (drop && rd_valid) drop <= 1'b0;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                fifo_cnt        <= cnt_nxt;
                pixel_valid     <= pix_fire;
                frame_read_done <= pix_fire && (pix_cnt == LAST_PIX_C);
                if (pix_fire) begin
                    {red, green, blue} <= head_pix;
                    sub_idx            <= sub_idx + 3'd1;
                    if (pix_cnt != LAST_PIX_C) pix_cnt <= pix_cnt + 1'b1;
                end else if (pixel_req) begin
                    {red, green, blue} <= 16'h0000;
                    if (state != S_IDLE) underflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hdr_frame_reader.sv
// Bench for hdr_frame_reader: RAM responder plus a pixel-queue reference model,
// directed scenarios followed by a randomized run.
module tb_hdr_frame_reader;

    localparam int WPF   = 6;
    localparam int BASE  = 256;
    localparam int AW    = 24;
    localparam int DEPTH = 4;
    localparam int TOTAL = WPF * 8;
    localparam logic [127:0] PATTERN = 128'hF800_07E0_001F_FFFF_0000_AAAA_5555_1234;

    logic          clk;
    logic          rst_n;
    logic          frame_start;
    logic          ram_busy;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [127:0]  rd_data;
    logic          rd_valid;
    logic          pixel_req;
    logic          pixel_valid;
    logic [4:0]    red;
    logic [5:0]    green;
    logic [4:0]    blue;
    logic          underflow;
    logic          frame_read_done;

    hdr_frame_reader #(
        .WORDS_PER_FRAME(WPF), .BASE_ADDR(BASE), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .ram_busy(ram_busy),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .pixel_req(pixel_req), .pixel_valid(pixel_valid), .red(red), .green(green),
        .blue(blue), .underflow(underflow), .frame_read_done(frame_read_done)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        int idx;
        int gen;
    } req_t;

    logic [127:0] ram [WPF];
    req_t         pend [$];
    logic [15:0]  pix_q [$];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   lat_min = 2;
    int   lat_max = 2;
    bit   stray_en = 1'b0;
    int   gen = 0;
    int   words_req = 0;
    int   consumed = 0;
    bit   active = 1'b0;
    logic exp_valid = 1'b0;
    logic exp_uf = 1'b0;
    logic exp_done = 1'b0;
    logic [15:0] exp_rgb = 16'h0;
    int   n_req = 0;
    int   n_done = 0;
    int   last_req_cyc = -1;
    int   last_req_addr = -1;
    int   drop_cyc = -1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive RAM response, vet any request, advance the model, compare outputs.
    task automatic tick();
        bit          del;
        req_t        e;
        logic [15:0] p;
        del = 1'b0;
        e   = '{0, 0, 0};
        if (pend.size() > 0 && pend[0].due == cyc) begin
            del      = 1'b1;
            e        = pend.pop_front();
            rd_valid = 1'b1;
            rd_data  = ram[e.idx];
        end else begin
            rd_valid = stray_en && (pend.size() == 0) && ($urandom_range(7) == 0);
            rd_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        #1;
        if (rst_n && rd_req) begin
            n_req++;
            check("req_while_busy", ram_busy, 0);
            check("req_with_start", frame_start, 0);
            check("req_outstanding", pend.size(), 0);
            check("req_frame_active", active, 1);
            check("req_slot_free", ((pix_q.size() + 7) / 8) < DEPTH, 1);
            check("req_word_limit", words_req < WPF, 1);
            check("rd_addr", rd_addr, AW'(BASE + words_req));
            pend.push_back('{cyc + $urandom_range(lat_max, lat_min), words_req, gen});
            words_req++;
            last_req_cyc  = cyc;
            last_req_addr = int'(rd_addr);
        end
        if (del && (!rst_n || frame_start || e.gen != gen)) drop_cyc = cyc;
        if (!rst_n) begin
            pix_q.delete();
            pend.delete();
            gen++;
            active = 1'b0; words_req = 0; consumed = 0;
            exp_valid = 1'b0; exp_uf = 1'b0; exp_done = 1'b0; exp_rgb = 16'h0;
        end else if (frame_start) begin
            pix_q.delete();
            gen++;
            active = 1'b1; words_req = 0; consumed = 0;
            exp_valid = 1'b0; exp_uf = 1'b0; exp_done = 1'b0;
        end else begin
            exp_valid = 1'b0;
            exp_done  = 1'b0;
            if (pixel_req) begin
                if (pix_q.size() > 0) begin
                    p = pix_q.pop_front();
                    exp_valid = 1'b1;
                    exp_rgb   = p;
                    consumed++;
                    if (consumed == TOTAL) begin
                        exp_done = 1'b1;
                        active   = 1'b0;
                    end
                end else begin
                    exp_rgb = 16'h0;
                    if (active) exp_uf = 1'b1;
                end
            end
            if (del && e.gen == gen)
                for (int k = 0; k < 8; k++) pix_q.push_back(rd_data[16*k +: 16]);
        end
        @(posedge clk);
        #1;
        check("pixel_valid", pixel_valid, exp_valid);
        check("rgb", {red, green, blue}, exp_rgb);
        check("underflow", underflow, exp_uf);
        check("frame_read_done", frame_read_done, exp_done);
        if (!rst_n) begin
            check("reset_rd_req", rd_req, 0);
            check("reset_rd_addr", rd_addr, 0);
        end
        if (frame_read_done === 1'b1) n_done++;
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n_req  = 0;
        n_done = 0;
    endtask

    initial begin
        bit          seen;
        int          gaps;
        logic [15:0] first_pix;
        rst_n = 1'b0; frame_start = 1'b0; ram_busy = 1'b0; pixel_req = 1'b0;
        rd_valid = 1'b0; rd_data = '0;
        for (int i = 0; i < WPF; i++)
            for (int k = 0; k < 8; k++) ram[i][16*k +: 16] = 16'(8 * i + k);
        @(negedge clk);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Full frame, fixed latency 2, consumer always requesting.
        pixel_req = 1'b1;
        start_frame();
        seen = 1'b0; gaps = 0;
        for (int i = 0; i < 2000 && n_done == 0; i++) begin
            tick();
            if (pixel_valid) seen = 1'b1;
            else if (seen) gaps++;
        end
        repeat (3) tick();
        check("B_done_once", n_done, 1);
        check("B_no_gaps", gaps, 0);
        check("B_words_fetched", n_req, WPF);

        // Directed pixel format, one pixel_req pulse at a time.
        ram[0] = PATTERN;
        pixel_req = 1'b0;
        start_frame();
        repeat (20) tick();
        for (int k = 0; k < 8; k++) begin
            pixel_req = 1'b1;
            tick();
            pixel_req = 1'b0;
            if (k == 0) begin
                check("C_pix0_red", red, 5'h02);
                check("C_pix0_green", green, 6'h11);
                check("C_pix0_blue", blue, 5'h14);
            end
            if (k == 3) check("C_pix3_black", {red, green, blue}, 16'h0000);
            if (k == 5) begin
                check("C_pix5_red", red, 5'h00);
                check("C_pix5_green", green, 6'h00);
                check("C_pix5_blue", blue, 5'h1F);
            end
            tick();
        end

        // Busy stall, then FIFO fill with no consumer.
        ram[0] = {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
        ram_busy = 1'b1;
        start_frame();
        repeat (10) tick();
        check("D_busy_no_req", n_req, 0);
        ram_busy = 1'b0;
        tick();
        check("D_release_one_req", n_req, 1);
        check("D_release_addr", last_req_addr, BASE);
        ram_busy = 1'b1;
        repeat (5) tick();
        check("D_busy_again_no_req", n_req, 1);
        ram_busy = 1'b0;
        repeat (40) tick();
        check("D_fifo_full_reqs", n_req, DEPTH);
        pixel_req = 1'b1;
        repeat (7) tick();
        pixel_req = 1'b0;
        repeat (4) tick();
        check("D_seven_pix_no_req", n_req, DEPTH);
        pixel_req = 1'b1;
        tick();
        pixel_req = 1'b0;
        repeat (4) tick();
        check("D_slot_freed_req", n_req, DEPTH + 1);
        pixel_req = 1'b1;
        for (int i = 0; i < 500 && n_done == 0; i++) tick();
        check("D_done", n_done, 1);
        repeat (3) tick();
        check("D_idle_no_underflow", underflow, 0);
        check("D_idle_no_valid", pixel_valid, 0);

        // Slow RAM starves the consumer.
        lat_min = 20; lat_max = 20;
        start_frame();
        seen = 1'b0;
        for (int i = 0; i < 400 && !(seen && !pixel_valid); i++) begin
            tick();
            if (pixel_valid) seen = 1'b1;
        end
        check("E_starved", seen && !pixel_valid, 1);
        check("E_underflow_set", underflow, 1);
        check("E_black", {red, green, blue}, 16'h0000);
        repeat (10) tick();
        check("E_underflow_sticky", underflow, 1);
        start_frame();
        check("E_underflow_cleared", underflow, 0);

        // Abort while a read is outstanding.
        for (int i = 0; i < WPF; i++) ram[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        lat_min = 6; lat_max = 6;
        pixel_req = 1'b0;
        start_frame();
        for (int i = 0; i < 100 && n_req < 2; i++) tick();
        check("F_two_reqs", n_req, 2);
        drop_cyc = -1;
        pixel_req = 1'b1;
        start_frame();
        for (int i = 0; i < 100 && n_req == 0; i++) tick();
        check("F_new_req_seen", n_req, 1);
        check("F_req_after_drop", (drop_cyc >= 0) && (last_req_cyc > drop_cyc), 1);
        check("F_first_addr", last_req_addr, BASE);
        first_pix = 16'hxxxx;
        for (int i = 0; i < 100 && !pixel_valid; i++) tick();
        if (pixel_valid) first_pix = {red, green, blue};
        check("F_first_pixel", first_pix, ram[0][15:0]);
        for (int i = 0; i < 1000 && n_done == 0; i++) tick();
        check("F_done", n_done, 1);

        // Randomized traffic with stray rd_valid, busy, and mid-frame restarts.
        stray_en = 1'b1; lat_min = 1; lat_max = 5;
        n_done = 0;
        for (int i = 0; i < 2500; i++) begin
            ram_busy  = ($urandom_range(3) == 0);
            pixel_req = 1'($urandom_range(1));
            frame_start = active ? ($urandom_range(299) == 0) : ($urandom_range(9) == 0);
            tick();
            frame_start = 1'b0;
        end
        check("G_frames_completed", n_done > 3, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
